// File: rtl/aes_pkg.sv
// Shared AES datapath types and the InvSubBytes sequencer state encoding.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    localparam int AES_NBYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } inv_sb_state_e;

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box, one byte in, one byte out; purely combinational.
// Zero latency; no handshake.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] c
);

    always_comb begin
        c = 8'h00;
        case (a)
            8'h00: c = 8'h52;  8'h01: c = 8'h09;  8'h02: c = 8'h6a;  8'h03: c = 8'hd5;
            8'h04: c = 8'h30;  8'h05: c = 8'h36;  8'h06: c = 8'ha5;  8'h07: c = 8'h38;
            8'h08: c = 8'hbf;  8'h09: c = 8'h40;  8'h0a: c = 8'ha3;  8'h0b: c = 8'h9e;
            8'h0c: c = 8'h81;  8'h0d: c = 8'hf3;  8'h0e: c = 8'hd7;  8'h0f: c = 8'hfb;
            8'h10: c = 8'h7c;  8'h11: c = 8'he3;  8'h12: c = 8'h39;  8'h13: c = 8'h82;
            8'h14: c = 8'h9b;  8'h15: c = 8'h2f;  8'h16: c = 8'hff;  8'h17: c = 8'h87;
            8'h18: c = 8'h34;  8'h19: c = 8'h8e;  8'h1a: c = 8'h43;  8'h1b: c = 8'h44;
            8'h1c: c = 8'hc4;  8'h1d: c = 8'hde;  8'h1e: c = 8'he9;  8'h1f: c = 8'hcb;
            8'h20: c = 8'h54;  8'h21: c = 8'h7b;  8'h22: c = 8'h94;  8'h23: c = 8'h32;
            8'h24: c = 8'ha6;  8'h25: c = 8'hc2;  8'h26: c = 8'h23;  8'h27: c = 8'h3d;
            8'h28: c = 8'hee;  8'h29: c = 8'h4c;  8'h2a: c = 8'h95;  8'h2b: c = 8'h0b;
            8'h2c: c = 8'h42;  8'h2d: c = 8'hfa;  8'h2e: c = 8'hc3;  8'h2f: c = 8'h4e;
            8'h30: c = 8'h08;  8'h31: c = 8'h2e;  8'h32: c = 8'ha1;  8'h33: c = 8'h66;
            8'h34: c = 8'h28;  8'h35: c = 8'hd9;  8'h36: c = 8'h24;  8'h37: c = 8'hb2;
            8'h38: c = 8'h76;  8'h39: c = 8'h5b;  8'h3a: c = 8'ha2;  8'h3b: c = 8'h49;
            8'h3c: c = 8'h6d;  8'h3d: c = 8'h8b;  8'h3e: c = 8'hd1;  8'h3f: c = 8'h25;
            8'h40: c = 8'h72;  8'h41: c = 8'hf8;  8'h42: c = 8'hf6;  8'h43: c = 8'h64;
            8'h44: c = 8'h86;  8'h45: c = 8'h68;  8'h46: c = 8'h98;  8'h47: c = 8'h16;
            8'h48: c = 8'hd4;  8'h49: c = 8'ha4;  8'h4a: c = 8'h5c;  8'h4b: c = 8'hcc;
            8'h4c: c = 8'h5d;  8'h4d: c = 8'h65;  8'h4e: c = 8'hb6;  8'h4f: c = 8'h92;
            8'h50: c = 8'h6c;  8'h51: c = 8'h70;  8'h52: c = 8'h48;  8'h53: c = 8'h50;
            8'h54: c = 8'hfd;  8'h55: c = 8'hed;  8'h56: c = 8'hb9;  8'h57: c = 8'hda;
            8'h58: c = 8'h5e;  8'h59: c = 8'h15;  8'h5a: c = 8'h46;  8'h5b: c = 8'h57;
            8'h5c: c = 8'ha7;  8'h5d: c = 8'h8d;  8'h5e: c = 8'h9d;  8'h5f: c = 8'h84;
            8'h60: c = 8'h90;  8'h61: c = 8'hd8;  8'h62: c = 8'hab;  8'h63: c = 8'h00;
            8'h64: c = 8'h8c;  8'h65: c = 8'hbc;  8'h66: c = 8'hd3;  8'h67: c = 8'h0a;
            8'h68: c = 8'hf7;  8'h69: c = 8'he4;  8'h6a: c = 8'h58;  8'h6b: c = 8'h05;
            8'h6c: c = 8'hb8;  8'h6d: c = 8'hb3;  8'h6e: c = 8'h45;  8'h6f: c = 8'h06;
            8'h70: c = 8'hd0;  8'h71: c = 8'h2c;  8'h72: c = 8'h1e;  8'h73: c = 8'h8f;
            8'h74: c = 8'hca;  8'h75: c = 8'h3f;  8'h76: c = 8'h0f;  8'h77: c = 8'h02;
            8'h78: c = 8'hc1;  8'h79: c = 8'haf;  8'h7a: c = 8'hbd;  8'h7b: c = 8'h03;
            8'h7c: c = 8'h01;  8'h7d: c = 8'h13;  8'h7e: c = 8'h8a;  8'h7f: c = 8'h6b;
            8'h80: c = 8'h3a;  8'h81: c = 8'h91;  8'h82: c = 8'h11;  8'h83: c = 8'h41;
            8'h84: c = 8'h4f;  8'h85: c = 8'h67;  8'h86: c = 8'hdc;  8'h87: c = 8'hea;
            8'h88: c = 8'h97;  8'h89: c = 8'hf2;  8'h8a: c = 8'hcf;  8'h8b: c = 8'hce;
            8'h8c: c = 8'hf0;  8'h8d: c = 8'hb4;  8'h8e: c = 8'he6;  8'h8f: c = 8'h73;
            8'h90: c = 8'h96;  8'h91: c = 8'hac;  8'h92: c = 8'h74;  8'h93: c = 8'h22;
            8'h94: c = 8'he7;  8'h95: c = 8'had;  8'h96: c = 8'h35;  8'h97: c = 8'h85;
            8'h98: c = 8'he2;  8'h99: c = 8'hf9;  8'h9a: c = 8'h37;  8'h9b: c = 8'he8;
            8'h9c: c = 8'h1c;  8'h9d: c = 8'h75;  8'h9e: c = 8'hdf;  8'h9f: c = 8'h6e;
            8'ha0: c = 8'h47;  8'ha1: c = 8'hf1;  8'ha2: c = 8'h1a;  8'ha3: c = 8'h71;
            8'ha4: c = 8'h1d;  8'ha5: c = 8'h29;  8'ha6: c = 8'hc5;  8'ha7: c = 8'h89;
            8'ha8: c = 8'h6f;  8'ha9: c = 8'hb7;  8'haa: c = 8'h62;  8'hab: c = 8'h0e;
            8'hac: c = 8'haa;  8'had: c = 8'h18;  8'hae: c = 8'hbe;  8'haf: c = 8'h1b;
            8'hb0: c = 8'hfc;  8'hb1: c = 8'h56;  8'hb2: c = 8'h3e;  8'hb3: c = 8'h4b;
            8'hb4: c = 8'hc6;  8'hb5: c = 8'hd2;  8'hb6: c = 8'h79;  8'hb7: c = 8'h20;
            8'hb8: c = 8'h9a;  8'hb9: c = 8'hdb;  8'hba: c = 8'hc0;  8'hbb: c = 8'hfe;
            8'hbc: c = 8'h78;  8'hbd: c = 8'hcd;  8'hbe: c = 8'h5a;  8'hbf: c = 8'hf4;
            8'hc0: c = 8'h1f;  8'hc1: c = 8'hdd;  8'hc2: c = 8'ha8;  8'hc3: c = 8'h33;
            8'hc4: c = 8'h88;  8'hc5: c = 8'h07;  8'hc6: c = 8'hc7;  8'hc7: c = 8'h31;
            8'hc8: c = 8'hb1;  8'hc9: c = 8'h12;  8'hca: c = 8'h10;  8'hcb: c = 8'h59;
            8'hcc: c = 8'h27;  8'hcd: c = 8'h80;  8'hce: c = 8'hec;  8'hcf: c = 8'h5f;
            8'hd0: c = 8'h60;  8'hd1: c = 8'h51;  8'hd2: c = 8'h7f;  8'hd3: c = 8'ha9;
            8'hd4: c = 8'h19;  8'hd5: c = 8'hb5;  8'hd6: c = 8'h4a;  8'hd7: c = 8'h0d;
            8'hd8: c = 8'h2d;  8'hd9: c = 8'he5;  8'hda: c = 8'h7a;  8'hdb: c = 8'h9f;
            8'hdc: c = 8'h93;  8'hdd: c = 8'hc9;  8'hde: c = 8'h9c;  8'hdf: c = 8'hef;
            8'he0: c = 8'ha0;  8'he1: c = 8'he0;  8'he2: c = 8'h3b;  8'he3: c = 8'h4d;
            8'he4: c = 8'hae;  8'he5: c = 8'h2a;  8'he6: c = 8'hf5;  8'he7: c = 8'hb0;
            8'he8: c = 8'hc8;  8'he9: c = 8'heb;  8'hea: c = 8'hbb;  8'heb: c = 8'h3c;
            8'hec: c = 8'h83;  8'hed: c = 8'h53;  8'hee: c = 8'h99;  8'hef: c = 8'h61;
            8'hf0: c = 8'h17;  8'hf1: c = 8'h2b;  8'hf2: c = 8'h04;  8'hf3: c = 8'h7e;
            8'hf4: c = 8'hba;  8'hf5: c = 8'h77;  8'hf6: c = 8'hd6;  8'hf7: c = 8'h26;
            8'hf8: c = 8'he1;  8'hf9: c = 8'h69;  8'hfa: c = 8'h14;  8'hfb: c = 8'h63;
            8'hfc: c = 8'h55;  8'hfd: c = 8'h21;  8'hfe: c = 8'h0c;  8'hff: c = 8'h7d;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes: LANES bytes per cycle, out_valid 16/LANES edges after accept.
// Single block in flight; DONE holds out_state until out_ready, in_ready only in IDLE.
module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam int N  = AES_NBYTES / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((LANES < 1) || (LANES > AES_NBYTES) || ((AES_NBYTES % LANES) != 0)) begin : g_bad_lanes
        $error("inv_sub_bytes: LANES must divide 16");
    end

    inv_sb_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    aes_state_t    buffer, buffer_nxt;
    logic [3:0]    base;
    aes_byte_t     lane_in  [LANES];
    aes_byte_t     lane_out [LANES];

    // First byte of the group handled this cycle; groups walk upward from byte 0.
    assign base = 4'(int'(cnt) * LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = buffer[{base + 4'(l), 3'b000} +: 8];

        inv_sbox u_inv_sbox (
            .a (lane_in[l]),
            .c (lane_out[l])
        );
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        buffer_nxt = buffer;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    buffer_nxt = in_state;
                    cnt_nxt    = '0;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    buffer_nxt[{base + 4'(l), 3'b000} +: 8] = lane_out[l];
                end
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            buffer <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            buffer <= buffer_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_state = buffer;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Scoreboard bench: one DUT per LANES value (1,2,4,8,16), GF(2^8)-derived reference S-box.
module tb_inv_sub_bytes;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [5];
    logic       in_ready  [5];
    logic       out_valid [5];
    logic       out_ready [5];
    aes_state_t in_state  [5];
    aes_state_t out_state [5];

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  rdy_mode = 0;
    bit  rnd_rdy [5];
    bit  do_final = 1'b0;
    aes_byte_t inv_tab [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) for (int i = 0; i < 5; i++) rnd_rdy[i] <= ($urandom_range(0, 3) != 0);
    always_comb for (int i = 0; i < 5; i++) out_ready[i] = (rdy_mode == 2) ? rnd_rdy[i] : (rdy_mode == 1);

    function automatic aes_byte_t gmul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic aes_byte_t ginv(input aes_byte_t x);
        aes_byte_t r;
        r = 8'h01;
        if (x == 8'h00) return 8'h00;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r;
    endfunction

    // Forward S-box from its definition: field inverse followed by the affine map.
    function automatic aes_byte_t fwd_sbox(input aes_byte_t x);
        aes_byte_t b, r;
        b = ginv(x);
        r = 8'h63;
        for (int k = 0; k < 5; k++) r = r ^ aes_byte_t'((b << k) | (b >> (8 - k)));
        return r;
    endfunction

    function automatic aes_state_t model(input aes_state_t s);
        aes_state_t o;
        for (int j = 0; j < 16; j++) o[8*j +: 8] = inv_tab[s[8*j +: 8]];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int idx, input bit want_out, input int budget, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (((want_out ? out_valid[idx] : in_ready[idx]) !== 1'b1) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk(nm, want_out ? out_valid[idx] : in_ready[idx], 1);
    endtask

    task automatic send(input int idx, input aes_state_t s);
        step();
        in_state[idx] = s;
        in_valid[idx] = 1'b1;
        wait_sig(idx, 1'b0, 300, "accept_wait");
        step();
        in_valid[idx] = 1'b0;
    endtask

    for (genvar g = 0; g < 5; g++) begin : inst
        localparam int L = 1 << g;
        localparam int N = 16 / L;
        aes_state_t exp_q [$];
        int  acc_q [$];
        bit  prev_ov = 1'b0;
        bit  busy = 1'b0;
        bit  fin = 1'b0;
        int  out_cnt = 0;
        int  t0;

        inv_sub_bytes #(.LANES(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g])
        );

        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                acc_q.delete();
                prev_ov = 1'b0;
                busy = 1'b0;
            end else begin
                if (busy) chk($sformatf("busy_in_ready_l%0d", L), in_ready[g], 0);
                if (out_valid[g] && !prev_ov) begin
                    t0 = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
                    chk($sformatf("latency_l%0d", L), cyc - t0, N);
                end
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_output_l%0d", L), exp_q.size(), 1);
                    end else begin
                        chk($sformatf("result_l%0d", L), out_state[g], exp_q.pop_front());
                    end
                    busy = 1'b0;
                    out_cnt++;
                end
                if (in_valid[g] && in_ready[g]) begin
                    exp_q.push_back(model(in_state[g]));
                    acc_q.push_back(cyc + 1);
                    busy = 1'b1;
                end
                prev_ov = out_valid[g];
            end
            if (do_final && !fin) begin
                fin = 1'b1;
                chk($sformatf("drained_l%0d", L), exp_q.size(), 0);
            end
        end
    end

    initial begin
        aes_state_t s;
        int base_cnt;
        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);
        for (int i = 0; i < 5; i++) begin
            in_valid[i] = 1'b0;
            in_state[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("reset_in_ready", in_ready[i], 1);
            chk("reset_out_valid", out_valid[i], 0);
            chk("reset_out_state", out_state[i], '0);
        end

        // Round trip: 16 blocks per lane count cover S(x) for every x, with random out_ready.
        step();
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 16; k++) begin
                for (int j = 0; j < 16; j++) s[8*j +: 8] = fwd_sbox(8'(16 * k + j));
                send(i, s);
            end
            wait_sig(i, 1'b0, 300, "roundtrip_drain");
        end

        step();
        rdy_mode = 1;
        send(2, 128'h76abd7fe2b670130c56f6bf27b777c63);
        wait_sig(2, 1'b1, 40, "basic_out_wait");
        chk("basic_vector", out_state[2], 128'h0f0e0d0c0b0a09080706050403020100);
        send(2, '0);
        wait_sig(2, 1'b1, 40, "zero_out_wait");
        chk("all_zero", out_state[2], {16{8'h52}});
        send(2, {16{8'h63}});
        wait_sig(2, 1'b1, 40, "x63_out_wait");
        chk("all_63", out_state[2], '0);

        // Backpressure with a stray in_valid pulse while DONE.
        step();
        rdy_mode = 0;
        s = {$urandom, $urandom, $urandom, $urandom};
        send(2, s);
        wait_sig(2, 1'b1, 40, "bp_out_wait");
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 3) begin
                in_state[2] = ~s;
                in_valid[2] = 1'b1;
            end
            if (k == 4) in_valid[2] = 1'b0;
            @(negedge clk);
            chk("bp_hold_state", out_state[2], model(s));
            chk("bp_in_ready_low", in_ready[2], 0);
            chk("bp_out_valid_high", out_valid[2], 1);
        end
        step();
        rdy_mode = 1;
        step();
        @(negedge clk);
        chk("bp_release_in_ready", in_ready[2], 1);
        chk("bp_release_out_valid", out_valid[2], 0);

        // Reset while BUSY with cnt == 2.
        s = {$urandom, $urandom, $urandom, $urandom};
        send(2, s);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", out_valid[2], 0);
        chk("midreset_in_ready", in_ready[2], 1);
        chk("midreset_out_state", out_state[2], '0);
        s = {$urandom, $urandom, $urandom, $urandom};
        send(2, s);
        wait_sig(2, 1'b1, 40, "post_reset_out_wait");
        chk("post_reset_block", out_state[2], model(s));

        // Back-to-back with in_valid and out_ready held high.
        step();
        base_cnt = inst[2].out_cnt;
        in_state[2] = {$urandom, $urandom, $urandom, $urandom};
        in_valid[2] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            int acc, hs;
            wait_sig(2, 1'b0, 40, "b2b_accept_wait");
            acc = cyc + 1;
            step();
            if (b < 7) in_state[2] = {$urandom, $urandom, $urandom, $urandom};
            else in_valid[2] = 1'b0;
            wait_sig(2, 1'b1, 40, "b2b_out_wait");
            hs = cyc + 1;
            chk("b2b_accept_to_handshake", hs - acc, 5);
        end
        repeat (3) step();
        chk("b2b_block_count", inst[2].out_cnt - base_cnt, 8);

        do_final = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
